// File: rtl/cpu_control_pkg.sv
// ---------------------------------------------------------------------------
// cpu_control_pkg: opcodes, ALU codes and sequencer state encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_control_pkg;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_EXEC3 = 4'd4,
    ST_EXEC4 = 4'd5,
    ST_EXEC5 = 4'd6,
    ST_EXEC6 = 4'd7,
    ST_EXEC7 = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  // Final execute step of each instruction; the step after it is T0.
  function automatic state_t last_step(input logic [4:0] opc);
    if (opc == OP_LD || opc == OP_ST)
      return ST_EXEC7;
    else if (opc == OP_LDI || (opc >= OP_ADD && opc <= OP_ORI))
      return ST_EXEC5;
    else if (opc == OP_NEG || opc == OP_NOT || opc == OP_JAL)
      return ST_EXEC4;
    else if (opc == OP_DIV || opc == OP_MUL || opc == OP_BR)
      return ST_EXEC6;
    else
      return ST_EXEC3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit: Moore fetch/decode/execute sequencer driving datapath strobes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit
  import cpu_control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON_out,
  output logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout,
  output logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CON_in,
  output logic        GRA, GRB, GRC, Rin, Rout,
  output logic        IncPC, Read, Write,
  output logic [4:0]  operation,
  output logic        Run,
  output logic        Clear
);

  state_t     state, next_state;
  logic [4:0] opcode;
  logic       is_mem, is_reg, is_imm, is_unary, is_muldiv;
  logic [4:0] imm_op;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
  assign is_reg    = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign imm_op    = (opcode == OP_ADDI) ? ALU_ADD :
                     (opcode == OP_ANDI) ? ALU_AND : ALU_OR;

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: next_state = ST_T0;
      ST_T0:    next_state = ST_T1;
      ST_T1:    next_state = ST_T2;
      ST_T2:    next_state = (Stop || opcode == OP_HALT) ? ST_HALT : ST_EXEC3;
      ST_EXEC3, ST_EXEC4, ST_EXEC5, ST_EXEC6, ST_EXEC7:
        next_state = (state == last_step(opcode)) ? ST_T0 : state_t'(state + 4'd1);
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_RESET;
    endcase
  end

  always_comb begin
    {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CON_in}     = '0;
    {GRA, GRB, GRC, Rin, Rout, IncPC, Read, Write}                          = '0;
    operation = 5'b00000;
    Clear     = 1'b0;
    Run       = 1'b1;
    case (state)
      ST_RESET: Clear = 1'b1;
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_EXEC3: begin
        if (is_mem) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_reg || is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (is_muldiv) begin
          GRA = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else begin
          case (opcode)
            OP_BR:   begin GRB = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
            OP_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_JAL:  begin PCout = 1'b1; Rin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_EXEC4: begin
        if (is_mem) begin
          Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
        end else if (is_reg) begin
          GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; operation = imm_op;
        end else if (is_unary) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else if (opcode == OP_JAL) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end
      end
      ST_EXEC5: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (opcode == OP_LDI || is_reg || is_imm) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (opcode == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
        end
      end
      ST_EXEC6: begin
        // Single-cycle memory: Read and MDRin share the step.
        if (opcode == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_muldiv) begin
          ZHighout = 1'b1; HIin = 1'b1;
        end else if (opcode == OP_BR && CON_out) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      ST_EXEC7: begin
        if (opcode == OP_LD) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          Write = 1'b1;
        end
      end
      ST_HALT: Run = 1'b0;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit: instruction-sequence model with per-cycle strobe compare. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

  logic        Clock = 1'b0, Reset = 1'b1, Stop = 1'b0, CON_out = 1'b0;
  logic [31:0] IR = 32'h0;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CON_in;
  logic GRA, GRB, GRC, Rin, Rout, IncPC, Read, Write, Run, Clear;
  logic [4:0] operation;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON_out(CON_out),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .BAout(BAout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CON_in(CON_in),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .operation(operation), .Run(Run), .Clear(Clear)
  );

  always #5 Clock = ~Clock;

  localparam logic [26:0] M_PCOUT = 27'd1 << 0,  M_ZLO  = 27'd1 << 1,  M_ZHI   = 27'd1 << 2;
  localparam logic [26:0] M_MDROUT = 27'd1 << 3, M_HIOUT = 27'd1 << 4, M_LOOUT = 27'd1 << 5;
  localparam logic [26:0] M_COUT = 27'd1 << 6,   M_INPORT = 27'd1 << 7, M_BAOUT = 27'd1 << 8;
  localparam logic [26:0] M_MARIN = 27'd1 << 9,  M_ZIN = 27'd1 << 10,  M_PCIN = 27'd1 << 11;
  localparam logic [26:0] M_MDRIN = 27'd1 << 12, M_IRIN = 27'd1 << 13, M_YIN = 27'd1 << 14;
  localparam logic [26:0] M_HIIN = 27'd1 << 15,  M_LOIN = 27'd1 << 16, M_OUTPIN = 27'd1 << 17;
  localparam logic [26:0] M_CONIN = 27'd1 << 18, M_GRA = 27'd1 << 19,  M_GRB = 27'd1 << 20;
  localparam logic [26:0] M_GRC = 27'd1 << 21,   M_RIN = 27'd1 << 22,  M_ROUT = 27'd1 << 23;
  localparam logic [26:0] M_INCPC = 27'd1 << 24, M_READ = 27'd1 << 25, M_WRITE = 27'd1 << 26;

  localparam logic [33:0] V_RESET = {1'b1, 1'b1, 5'b0, 27'b0};
  localparam logic [33:0] V_HALT  = 34'b0;

  logic [26:0] strobes;
  logic [33:0] obs;
  assign strobes = {Write, Read, IncPC, Rout, Rin, GRC, GRB, GRA, CON_in, OutPortin, LOin,
                    HIin, Yin, IRin, MDRin, PCin, Zin, MARin, BAout, InPortout, Cout, LOout,
                    HIout, MDRout, ZHighout, Zlowout, PCout};
  assign obs = {Clear, Run, operation, strobes};

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One expected output word per cycle, consumed mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      logic [33:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%h expected=%h", $time, obs, e);
      end
    end
  end

  task automatic push(input logic [26:0] st, input logic [4:0] op);
    exp_q.push_back({1'b0, 1'b1, op, st});
  endtask

  task automatic model_fetch();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0);
    push(M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
  endtask

  // Full per-cycle strobe sequence of one instruction, from the opcode table.
  task automatic model_instr(input logic [31:0] ir, input logic con);
    logic [4:0] opc;
    int o;
    opc = ir[31:27];
    o = int'(opc);
    model_fetch();
    if (o == 0 || o == 1 || o == 2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      if (o == 1) push(M_ZLO | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLO | M_MARIN, 5'd0);
        if (o == 0) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
    end else if (o >= 3 && o <= 11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZIN, opc);
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (o >= 12 && o <= 14) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, (o == 12) ? 5'd3 : (o == 13) ? 5'd5 : 5'd6);
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (o == 15 || o == 16) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0);
      push(M_GRB | M_ROUT | M_ZIN, opc);
      push(M_ZLO | M_LOIN, 5'd0);
      push(M_ZHI | M_HIIN, 5'd0);
    end else if (o == 17 || o == 18) begin
      push(M_GRB | M_ROUT | M_ZIN, opc);
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (o == 19) begin
      push(M_GRB | M_ROUT | M_CONIN, 5'd0);
      push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      push(con ? (M_ZLO | M_PCIN) : 27'd0, 5'd0);
    end else if (o == 20) push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    else if (o == 21) begin
      push(M_PCOUT | M_RIN, 5'd0);
      push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    end
    else if (o == 22) push(M_INPORT | M_GRA | M_RIN, 5'd0);
    else if (o == 23) push(M_GRA | M_ROUT | M_OUTPIN, 5'd0);
    else if (o == 24) push(M_HIOUT | M_GRA | M_RIN, 5'd0);
    else if (o == 25) push(M_LOOUT | M_GRA | M_RIN, 5'd0);
    else push(27'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 100);
    chk("drain_timeout", 34'(exp_q.size()), 34'd0);
    exp_q.delete();
  endtask

  task automatic reset_from(input logic [33:0] cur);
    int n;
    exp_q.push_back(cur);
    exp_q.push_back(V_RESET);
    Reset = 1'b1;
    tick();
    chk("reset_clear", 34'(Clear), 34'd1);
    Reset = 1'b0;
    wait_drain(n);
  endtask

  logic [31:0] irs[20] = '{32'h11800087, 32'h1A920000, 32'h08000000, 32'h60000000,
                           32'h68000000, 32'h70000000, 32'h88000000, 32'h90000000,
                           32'h80000000, 32'h78000000, 32'hA0000000, 32'hA8000000,
                           32'hB0000000, 32'hB8000000, 32'hC0000000, 32'hC8000000,
                           32'hD0000000, 32'hF8000000, 32'h58000000, 32'h20000000};
  int cycs[20] = '{8, 6, 6, 6, 6, 6, 5, 5, 7, 7, 4, 5, 4, 4, 4, 4, 4, 4, 6, 6};

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick();
    tick();
    chk("reset_state", obs, V_RESET);
    exp_q.push_back(V_RESET);
    Reset = 1'b0;
    wait_drain(n);

    // ld R4,0x54 stepped cycle by cycle
    IR = 32'h02000054;
    model_instr(IR, 1'b0);
    chk("ld_t0", 34'({PCout, MARin, IncPC, Zin}), 34'hF);
    tick(); chk("ld_t1", 34'({Zlowout, PCin, Read, MDRin}), 34'hF);
    tick(); chk("ld_t2", 34'({MDRout, IRin}), 34'h3);
    tick(); tick(); chk("ld_exec4_op", 34'(operation), 34'd3);
    tick(); tick(); chk("ld_exec6_read_mdrin", 34'({Read, MDRin}), 34'h3);
    tick(); chk("ld_exec7_rin", 34'(Rin), 34'd1);
    tick(); chk("ld_back_t0", 34'({PCout, MARin, Clear}), 34'h6);
    chk("ld_queue_empty", 34'(exp_q.size()), 34'd0);

    for (int i = 0; i < 20; i++) begin
      IR = irs[i];
      model_instr(IR, 1'b0);
      wait_drain(n);
      chk($sformatf("cycles_ir_%h", irs[i]), 34'(n), 34'(cycs[i]));
    end

    // br taken then not taken
    for (int k = 0; k < 2; k++) begin
      IR = 32'h98000000;
      CON_out = (k == 0);
      model_instr(IR, CON_out);
      repeat (6) tick();
      chk($sformatf("br_exec6_pcin_con%0d", CON_out), 34'(PCin), 34'(k == 0));
      wait_drain(n);
    end
    CON_out = 1'b0;

    // Reset pulse during ld EXEC5
    IR = 32'h02000054;
    model_instr(IR, 1'b0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    exp_q.push_back(V_RESET);
    repeat (5) tick();
    chk("midld_exec5_marin", 34'({Zlowout, MARin}), 34'h3);
    Reset = 1'b1;
    tick();
    chk("midld_reset_state", obs, V_RESET);
    Reset = 1'b0;
    wait_drain(n);
    chk("midld_t0", 34'({PCout, Clear}), 34'h2);

    // halt opcode: sticky for 20 cycles
    IR = 32'hD8000000;
    model_fetch();
    repeat (20) exp_q.push_back(V_HALT);
    wait_drain(n);
    chk("halt_run_low", 34'(Run), 34'd0);
    reset_from(V_HALT);

    // Stop sampled in T2 halts an ordinary instruction
    IR = 32'h1A920000;
    Stop = 1'b1;
    model_fetch();
    repeat (5) exp_q.push_back(V_HALT);
    wait_drain(n);
    chk("stop_halt_state", obs, V_HALT);
    Stop = 1'b0;
    reset_from(V_HALT);

    IR = 32'h11800087;
    model_instr(IR, 1'b0);
    wait_drain(n);
    chk("st_after_halt_cycles", 34'(n), 34'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
